// File: rtl/unlock_attempt_scheduler_if.sv
// Requester and datapath handshake bundle for unlock_attempt_scheduler.
// master is the scheduler's view; slave is the requesters/datapath side.
interface unlock_attempt_scheduler_if #(
    parameter int N = 4
);
    logic [1:0]   req_valid;
    logic [N-1:0] req_data0;
    logic [N-1:0] req_data1;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_code;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         unlock;
    logic         pwd_incorrect;

    modport master (
        input  req_valid, req_data0, req_data1, p_ready, unlock, pwd_incorrect,
        output req_ready, rsp_valid, rsp_code, p_data, p_valid
    );

    modport slave (
        output req_valid, req_data0, req_data1, p_ready, unlock, pwd_incorrect,
        input  req_ready, rsp_valid, rsp_code, p_data, p_valid
    );
endinterface

// File: rtl/unlock_attempt_scheduler.sv
// Round-robin front end for the unlock datapath: one attempt in flight,
// verdict/timeout response, consecutive-failure count and timed lockout.
module unlock_attempt_scheduler #(
    parameter int N           = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    unlock_attempt_scheduler_if.master    bus,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] RC_OK     = 2'b00;
    localparam logic [1:0] RC_INC    = 2'b01;
    localparam logic [1:0] RC_LOCKED = 2'b10;
    localparam logic [1:0] RC_TMO    = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          rr;
    logic          gnt_q;
    logic          win;
    logic [N-1:0]  code_q;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] tmo_cnt;

    assign bus.p_data = code_q;

    // Grant is combinational so the request handshake completes in the IDLE cycle.
    always_comb begin
        win = rr;
        if (bus.req_valid == 2'b01)      win = 1'b0;
        else if (bus.req_valid == 2'b10) win = 1'b1;
        bus.req_ready = 2'b00;
        if (state == IDLE && rst_n && bus.req_valid != 2'b00) bus.req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr            <= 1'b0;
            gnt_q         <= 1'b0;
            code_q        <= '0;
            tmo_cnt       <= '0;
            bus.p_valid   <= 1'b0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_code  <= RC_OK;
            locked_out    <= 1'b0;
            fail_cnt      <= '0;
            lock_cnt      <= '0;
        end else begin
            bus.rsp_valid <= 2'b00;

            // Lockout timer runs regardless of what the attempt FSM is doing.
            if (locked_out) begin
                if (lock_cnt == LW'(1)) begin
                    locked_out <= 1'b0;
                    fail_cnt   <= '0;
                    lock_cnt   <= '0;
                end else begin
                    lock_cnt <= lock_cnt - LW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid != 2'b00) begin
                        gnt_q  <= win;
                        code_q <= win ? bus.req_data1 : bus.req_data0;
                        if (locked_out) begin
                            state              <= RESP;
                            bus.rsp_valid[win] <= 1'b1;
                            bus.rsp_code       <= RC_LOCKED;
                        end else begin
                            state       <= ISSUE;
                            bus.p_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.p_ready) begin
                        bus.p_valid <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // pwd_incorrect wins over unlock so a confused datapath fails safe.
                    if (bus.pwd_incorrect || bus.unlock || tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state                <= RESP;
                        bus.rsp_valid[gnt_q] <= 1'b1;
                        bus.rsp_code         <= bus.pwd_incorrect ? RC_INC :
                                                bus.unlock        ? RC_OK  : RC_TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    rr    <= ~gnt_q;
                    if (bus.rsp_code == RC_OK) begin
                        fail_cnt <= '0;
                    end else if (bus.rsp_code == RC_INC && fail_cnt != FW'(MAX_FAIL)) begin
                        fail_cnt <= fail_cnt + FW'(1);
                        if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                            locked_out <= 1'b1;
                            lock_cnt   <= LW'(LOCK_CYCLES);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unlock_attempt_scheduler.sv
// Randomized bench for unlock_attempt_scheduler against a timestamp-based
// attempt model, plus directed scenarios with hand-computed latencies.
module tb_unlock_attempt_scheduler;
    localparam int N           = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int TIMEOUT     = 32;
    localparam int FW          = $clog2(MAX_FAIL + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          locked_out;
    logic [FW-1:0] fail_cnt;

    unlock_attempt_scheduler_if #(.N(N)) bus ();

    unlock_attempt_scheduler #(
        .N(N), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stimulus knobs
    int req_pct [2];
    int code_mode;
    int p_ready_pct;
    int silent_pct;
    bit noise;
    int stall_left;

    // requesters hold valid/data until accepted
    bit           pend  [2];
    logic [N-1:0] rdata [2];

    // reference model: one attempt described by cycle timestamps
    int           cyc;
    bit           m_rr;
    int           m_fail;
    int           lock_start;
    bit           m_busy;
    bit           m_gnt;
    bit           m_rej;
    logic [N-1:0] m_code;
    logic [1:0]   m_rsp;
    int           acc_cyc, phs_cyc, resp_cyc, verdict_cyc;

    // observations of the DUT for the directed literal checks
    int         n_rsp = 0;
    int         dut_acc = 0;
    int         last_lat = 0;
    int         lock_hi = 0;
    int         pv_cnt = 0;
    logic [1:0] last_code = 2'b00;
    bit         grants [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_locked(input int c);
        return lock_start >= 0 && c >= lock_start && c < lock_start + LOCK_CYCLES;
    endfunction

    task automatic model_reset();
        cyc = 0; m_rr = 1'b0; m_fail = 0; lock_start = -1;
        m_busy = 1'b0; m_gnt = 1'b0; m_rej = 1'b0; m_code = '0; m_rsp = 2'b00;
        acc_cyc = -1; phs_cyc = -1; resp_cyc = -1; verdict_cyc = -1;
        pend[0] = 1'b0; pend[1] = 1'b0; stall_left = 0;
    endtask

    task automatic post(input int i, input logic [N-1:0] code);
        pend[i]  = 1'b1;
        rdata[i] = code;
    endtask

    task automatic step();
        bit         exp_pv, unl, inc, win;
        logic [1:0] rv, exp_rdy, exp_rsp;
        @(posedge clk);
        cyc++;
        #1;
        // effects of the response cycle that just ended
        if (m_busy && resp_cyc == cyc - 1) begin
            m_busy = 1'b0;
            m_rr   = ~m_gnt;
            if (m_rsp == 2'b00) m_fail = 0;
            else if (m_rsp == 2'b01 && m_fail < MAX_FAIL) begin
                m_fail++;
                if (m_fail == MAX_FAIL) lock_start = cyc;
            end
        end
        if (lock_start >= 0 && cyc == lock_start + LOCK_CYCLES) m_fail = 0;

        for (int i = 0; i < 2; i++)
            if (!pend[i] && int'($urandom_range(99)) < req_pct[i]) begin
                pend[i] = 1'b1;
                case (code_mode)
                    0:       rdata[i] = 4'hA;
                    1:       rdata[i] = 4'h3;
                    default: rdata[i] = ($urandom_range(1) == 0) ? 4'hA : N'($urandom);
                endcase
            end
        rv = {pend[1], pend[0]};
        bus.req_valid = rv;
        bus.req_data0 = rdata[0];
        bus.req_data1 = rdata[1];

        exp_pv = m_busy && !m_rej && cyc > acc_cyc && phs_cyc < 0;
        if (exp_pv && stall_left > 0) begin
            bus.p_ready = 1'b0;
            stall_left--;
        end else begin
            bus.p_ready = int'($urandom_range(99)) < p_ready_pct;
        end

        // datapath: verdict 3 cycles after the code handshake; junk only where it must be ignored
        unl = 1'b0; inc = 1'b0;
        if (verdict_cyc == cyc) begin
            if (m_code == 4'hA) unl = 1'b1;
            else begin
                inc = 1'b1;
                unl = ($urandom_range(3) == 0);
            end
        end else if (noise && (exp_pv || !m_busy || resp_cyc == cyc)) begin
            unl = ($urandom_range(1) == 1);
            inc = ($urandom_range(1) == 1);
        end
        bus.unlock        = unl;
        bus.pwd_incorrect = inc;

        win     = (rv == 2'b10) ? 1'b1 : (rv == 2'b01) ? 1'b0 : m_rr;
        exp_rdy = (!m_busy && rv != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
        exp_rsp = (m_busy && resp_cyc == cyc) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00;

        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("p_valid", 32'(bus.p_valid), 32'(exp_pv));
        if (exp_pv) chk("p_data", 32'(bus.p_data), 32'(m_code));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp != 2'b00) chk("rsp_code", 32'(bus.rsp_code), 32'(m_rsp));
        chk("locked_out", 32'(locked_out), 32'(m_locked(cyc)));
        chk("fail_cnt", 32'(fail_cnt), m_fail);

        if (bus.req_ready != 2'b00) begin
            dut_acc = cyc;
            grants.push_back(bus.req_ready[1]);
        end
        if (bus.rsp_valid != 2'b00) begin
            n_rsp++;
            last_code = bus.rsp_code;
            last_lat  = cyc - dut_acc;
        end
        if (locked_out) lock_hi++;
        if (bus.p_valid) pv_cnt++;

        // advance the model with this cycle's events
        if (exp_rdy != 2'b00) begin
            m_busy = 1'b1; m_gnt = win; acc_cyc = cyc; m_code = rdata[win];
            pend[win] = 1'b0;
            m_rej = m_locked(cyc);
            phs_cyc = -1; verdict_cyc = -1;
            resp_cyc = m_rej ? cyc + 1 : -1;
            m_rsp = 2'b10;
        end else if (exp_pv && bus.p_ready) begin
            phs_cyc     = cyc;
            verdict_cyc = (int'($urandom_range(99)) < silent_pct) ? -1 : cyc + 3;
        end else if (m_busy && !m_rej && phs_cyc >= 0 && cyc > phs_cyc && resp_cyc < 0) begin
            if (inc)                             begin m_rsp = 2'b01; resp_cyc = cyc + 1; end
            else if (unl)                        begin m_rsp = 2'b00; resp_cyc = cyc + 1; end
            else if (cyc == phs_cyc + TIMEOUT)   begin m_rsp = 2'b11; resp_cyc = cyc + 1; end
        end
    endtask

    task automatic run_until_rsp(input int budget);
        int start, k;
        start = n_rsp;
        k = 0;
        while (n_rsp == start && k < budget) begin
            step();
            k++;
        end
        chk("rsp_within_budget", 32'(n_rsp != start), 1);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((pend[0] || pend[1] || m_busy) && k < budget) begin
            step();
            k++;
        end
        chk("drain_within_budget", 32'(!(pend[0] || pend[1] || m_busy)), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_code", 32'(bus.rsp_code), 0);
        chk("rst_p_valid", 32'(bus.p_valid), 0);
        chk("rst_p_data", 32'(bus.p_data), 0);
        chk("rst_locked_out", 32'(locked_out), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        bus.req_valid = 2'b00; bus.unlock = 1'b0; bus.pwd_incorrect = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int pv_before, rsp_before, k;
        req_pct[0] = 0; req_pct[1] = 0;
        code_mode = 0; p_ready_pct = 100; silent_pct = 0; noise = 1'b0;
        rdata[0] = '0; rdata[1] = '0;
        model_reset();
        bus.req_valid = 2'b00; bus.req_data0 = '0; bus.req_data1 = '0;
        bus.p_ready = 1'b0; bus.unlock = 1'b0; bus.pwd_incorrect = 1'b0;
        #12 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // correct code from requester 0: accept T, p at T+1, verdict T+4, response T+5
        post(0, 4'hA);
        run_until_rsp(100);
        chk("t1_latency", last_lat, 5);
        chk("t1_code", 32'(last_code), 0);
        chk("t1_fail_cnt", 32'(fail_cnt), 0);

        // three wrong codes lead to lockout
        lock_hi = 0;
        for (int i = 0; i < 3; i++) begin
            post(0, 4'h3);
            run_until_rsp(100);
            chk("t2_code", 32'(last_code), 1);
        end
        chk("t2_fail_cnt_at_third_rsp", 32'(fail_cnt), 2);

        // attempt during lockout is bounced without touching the datapath
        pv_before = pv_cnt;
        post(0, 4'hA);
        run_until_rsp(10);
        chk("t3_code", 32'(last_code), 2);
        chk("t3_latency", last_lat, 1);
        chk("t3_fail_cnt", 32'(fail_cnt), 3);
        chk("t3_p_valid_cycles", pv_cnt - pv_before, 0);
        repeat (25) step();
        chk("t2_lock_cycles", lock_hi, 16);
        chk("t2_fail_after_lock", 32'(fail_cnt), 0);

        // both requesters valid from reset: strict alternation starting at 0
        do_reset();
        grants.delete();
        code_mode = 0; req_pct[0] = 100; req_pct[1] = 100;
        for (int i = 0; i < 4; i++) begin
            run_until_rsp(100);
            chk("t4_code", 32'(last_code), 0);
        end
        req_pct[0] = 0; req_pct[1] = 0;
        drain(200);
        chk("t4_grant0", 32'(grants[0]), 0);
        chk("t4_grant1", 32'(grants[1]), 1);
        chk("t4_grant2", 32'(grants[2]), 0);
        chk("t4_grant3", 32'(grants[3]), 1);

        // stalled p_ready and a silent datapath: accept T, p handshake T+6, timeout response T+39
        post(0, 4'h3);
        run_until_rsp(100);
        chk("t5_pre_code", 32'(last_code), 1);
        stall_left = 5; silent_pct = 100;
        pv_before = pv_cnt;
        post(0, 4'h3);
        run_until_rsp(100);
        silent_pct = 0;
        chk("t5_code", 32'(last_code), 3);
        chk("t5_latency", last_lat, 39);
        chk("t5_p_valid_cycles", pv_cnt - pv_before, 6);
        step();
        chk("t5_fail_cnt", 32'(fail_cnt), 1);
        drain(20);

        // reset in the middle of WAIT drops the attempt silently
        post(0, 4'hA);
        k = 0;
        while (!(m_busy && phs_cyc >= 0 && cyc == phs_cyc + 1) && k < 50) begin
            step();
            k++;
        end
        chk("t6_reached_wait", 32'(k < 50), 1);
        #2 rst_n = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        bus.req_valid = 2'b00; bus.unlock = 1'b0; bus.pwd_incorrect = 1'b0;
        #1 check_reset_outputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_rsp_in_reset", 32'(bus.rsp_valid), 0);
        end
        model_reset();
        rst_n = 1'b1;
        post(0, 4'hA);
        run_until_rsp(100);
        chk("t6_latency", last_lat, 5);
        chk("t6_code", 32'(last_code), 0);

        // randomized traffic with stalls, silent verdicts and ignored verdict noise
        rsp_before = n_rsp;
        req_pct[0] = 35; req_pct[1] = 35; code_mode = 2;
        p_ready_pct = 60; silent_pct = 10; noise = 1'b1;
        repeat (4000) step();
        req_pct[0] = 0; req_pct[1] = 0; noise = 1'b0;
        drain(500);
        chk("t7_activity", 32'((n_rsp - rsp_before) > 20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/unlock_attempt_scheduler.md
# unlock_attempt_scheduler

Front-end controller for the password unlocking datapath. It arbitrates password attempts from two requesters (keypad, remote) round-robin and forwards one N-bit code at a time over the datapath's parallel valid/ready port. It then waits for the unlock or pwd_incorrect verdict and returns a coded response to the requester that was granted. It also counts consecutive failures and enforces a timed lockout, during which attempts are rejected without reaching the datapath.

## Interface
- N, 4: password width in bits.
- MAX_FAIL, 3: consecutive incorrect verdicts that trigger lockout (≥1).
- LOCK_CYCLES, 16: lockout duration in clk cycles (≥1).
- TIMEOUT, 32: maximum cycles spent in WAIT before a verdict is declared missing (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  attempt pending, one bit per requester.
- req_data0 / req_data1  in  N  code from requester 0 / 1.
- req_ready  out  2  one-hot grant/accept.
- rsp_valid  out  2  one-hot, one-cycle response pulse to the granted requester.
- rsp_code  out  2  response code: 00 OK, 01 INCORRECT, 10 LOCKED, 11 TIMEOUT. Valid only with rsp_valid.
- p_data  out  N  code sent to the datapath.
- p_valid  out  1  code valid.
- p_ready  in  1  datapath accepts the code.
- unlock  in  1  datapath verdict: correct.
- pwd_incorrect  in  1  datapath verdict: wrong.
- locked_out  out  1  lockout active.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive-failure count.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitration is combinational over req_valid. Pointer rr (reset 0) marks the priority requester. If only one requester is valid, it wins.
  - req_ready[g] is asserted in the same cycle for the winner g. The handshake completes that cycle.
  - The controller captures req_data_g into code_q and g into gnt_q.
  - If locked_out=1, the next state is RESP with code LOCKED. Otherwise the next state is ISSUE.
- **ISSUE**
  - p_valid=1 and p_data=code_q, held stable until p_ready=1.
  - On handshake: go to WAIT and clear tmo_cnt.
- **WAIT**
  - unlock and pwd_incorrect are sampled each cycle, starting the cycle after the p handshake.
  - pwd_incorrect=1 → INCORRECT. This takes precedence if both are high (fail-safe).
  - unlock=1 alone → OK.
  - tmo_cnt reaching TIMEOUT-1 with no verdict → TIMEOUT.
  - Every outcome goes to RESP.
- **RESP**
  - rsp_valid[gnt_q]=1 for exactly one cycle, with rsp_code set.
  - rr becomes ~gnt_q.
  - Return to IDLE.
- Failure accounting is updated in the RESP cycle:
  - OK: fail_cnt cleared.
  - INCORRECT: fail_cnt incremented. If it reaches MAX_FAIL, locked_out is set and lock_cnt is loaded with LOCK_CYCLES.
  - TIMEOUT and LOCKED: fail_cnt unchanged.
- Lockout:
  - lock_cnt decrements every cycle while locked_out=1.
  - When it reaches 1, the next cycle clears locked_out and fail_cnt. locked_out is therefore high for exactly LOCK_CYCLES cycles.
  - Lockout runs independently of FSM state.
- fail_cnt saturates at MAX_FAIL and never wraps.
- req_ready is 0 outside IDLE. Requesters hold valid/data until accepted.

## Timing
- Reset values:
  - State IDLE; rr=0.
  - req_ready=0, rsp_valid=0, rsp_code=00.
  - p_valid=0, p_data=0.
  - locked_out=0, fail_cnt=0, lock_cnt=0, tmo_cnt=0.
- Reset is asynchronous at assertion. An attempt in flight is abandoned with no rsp_valid. The datapath shares rst_n.
- Latency:
  - Request handshake (cycle T) → p_valid at T+1.
  - Verdict seen at cycle V → rsp_valid at V+1.
  - Locked rejection: handshake T → rsp_valid at T+1.
- Throughput: one attempt in flight. The next request can be accepted in the cycle after RESP.
- Boundary cases:
  - Both requesters valid in IDLE: rr winner served first. The other is served on the next IDLE visit.
  - Verdict asserted during ISSUE is ignored.
  - Lockout expiring in the same cycle as an IDLE handshake: the locked_out value in that cycle decides.

## Test plan
- Bench model: datapath raises unlock 3 cycles after the p handshake for code 4'hA, and pwd_incorrect otherwise; p_ready is stalled where noted.
- Req0 sends 4'hA → p_valid at T+1, p_data=A, rsp_valid=01, code 00, fail_cnt=0.
- Three req0 attempts with 4'h3 → codes 01,01,01; locked_out rises after the third RESP, stays high exactly 16 cycles, then fail_cnt=0.
- Attempt during lockout → rsp code 10 at T+1, p_valid never asserted, fail_cnt unchanged.
- Both req_valid high from reset → req0 granted first, then req1; rr alternates over 4 back-to-back attempts.
- p_ready held low 5 cycles → p_valid and p_data stable for the full stall. With the model silent, code 11 arrives 32 cycles into WAIT and fail_cnt is unchanged.
- rst_n low mid-WAIT → all outputs reset immediately, no rsp_valid. After release, 4'hA succeeds normally.
